// File: rtl/prog_fsm_core_if.sv
// rtl/prog_fsm_core_if.sv - input/config/output bundle of the table-programmable FSM core
interface prog_fsm_core_if #(
  parameter int NS_W = 5,
  parameter int NI   = 18,
  parameter int NO   = 19,
  parameter int SW   = $clog2(NI),
  parameter int CW   = NO + 2*NS_W + 1 + SW
);
  logic [NI-1:0]   in;
  logic            en;
  logic            step;
  logic            cfg_we;
  logic [NS_W-1:0] cfg_addr;
  logic [CW-1:0]   cfg_data;
  logic [NO-1:0]   out;
  logic [NS_W-1:0] state;
  logic            stall;

  modport master (
    output in, en, step, cfg_we, cfg_addr, cfg_data,
    input  out, state, stall
  );

  modport slave (
    input  in, en, step, cfg_we, cfg_addr, cfg_data,
    output out, state, stall
  );
endinterface

// File: rtl/prog_fsm_core.sv
// rtl/prog_fsm_core.sv - table-programmable Moore FSM with single-step and self-loop stall detection
module prog_fsm_core #(
  parameter int NS_W      = 5,
  parameter int NI        = 18,
  parameter int NO        = 19,
  parameter int RST_STATE = 0,
  parameter int STALL_N   = 15
) (
  input logic              clk,
  input logic              rst,
  prog_fsm_core_if.slave   bus
);
  localparam int SW    = $clog2(NI);
  localparam int CW    = NO + 2*NS_W + 1 + SW;
  localparam int DEPTH = 1 << NS_W;

  typedef enum logic [1:0] {
    MODE_RESET,
    MODE_RUN,
    MODE_HALT,
    MODE_STEPPING
  } mode_e;

  mode_e mode;

  logic [CW-1:0]   tbl [DEPTH];
  logic [NS_W-1:0] state_q, state_d;
  logic [NO-1:0]   out_q, out_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            stall_q, stall_d;

  logic            adv;
  logic [SW-1:0]   sel;
  logic            pol;
  logic            cond;
  logic [NS_W-1:0] nxt_t, nxt_f, nxt;

  // Next-state logic reads the table as it stood before any same-edge write.
  always_comb begin
    mode = MODE_HALT;
    if (rst)           mode = MODE_RESET;
    else if (bus.en)   mode = MODE_RUN;
    else if (bus.step) mode = MODE_STEPPING;
    adv = (mode == MODE_RUN) || (mode == MODE_STEPPING);

    sel   = tbl[state_q][CW-1 -: SW];
    pol   = tbl[state_q][NO + 2*NS_W];
    nxt_t = tbl[state_q][NO + NS_W +: NS_W];
    nxt_f = tbl[state_q][NO +: NS_W];

    cond = 1'b0;
    if (32'(sel) < NI) cond = bus.in[sel];
    cond = cond ^ pol;
    nxt  = cond ? nxt_t : nxt_f;

    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    if (adv) begin
      state_d = nxt;
      out_d   = tbl[nxt][NO-1:0];
      if (nxt == state_q) begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end else begin
        cnt_d = 8'd0;
      end
      stall_d = (32'(cnt_d) >= STALL_N);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NS_W'(RST_STATE);
      out_q   <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      if (bus.cfg_we) tbl[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  assign bus.out   = out_q;
  assign bus.state = state_q;
  assign bus.stall = stall_q;
endmodule

// File: tb/tb_prog_fsm_core.sv
// tb/tb_prog_fsm_core.sv - directed self-checking bench for prog_fsm_core
module tb_prog_fsm_core;
  localparam int NS_W = 5;
  localparam int NI   = 18;
  localparam int NO   = 19;
  localparam int CW   = 35;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  prog_fsm_core_if #(.NS_W(NS_W), .NI(NI), .NO(NO)) bus ();

  prog_fsm_core #(.NS_W(NS_W), .NI(NI), .NO(NO), .RST_STATE(0), .STALL_N(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [CW-1:0] ent(input int sel, input int pol, input int nt,
                                        input int nf, input int o);
    logic [4:0]    s5, t5, f5;
    logic [NO-1:0] ov;
    s5 = sel[4:0];
    t5 = nt[4:0];
    f5 = nf[4:0];
    ov = o[NO-1:0];
    return {s5, pol[0], t5, f5, ov};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int addr, input logic [CW-1:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr[NS_W-1:0];
    bus.cfg_data = data;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    bus.in = '0; bus.en = 1'b0; bus.step = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.state !== 5'd0 || bus.out !== 19'd0 || bus.stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: state=%0d out=%h stall=%b want 0/0/0", bus.state, bus.out, bus.stall);
    end
    bus.en = 1'b1;
    bus.in = 18'h3FFFF;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1 || k == 14 || k == 15) begin
        n_cmp++;
        if (bus.state !== 5'd0 || bus.out !== 19'd0 || bus.stall !== (k == 15)) begin
          n_bad++;
          $display("FAIL default_selfloop adv%0d: state=%0d out=%h stall=%b want 0/0/%b",
                   k, bus.state, bus.out, bus.stall, (k == 15));
        end
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_toggle();
    logic [4:0]  exp_s;
    logic [18:0] exp_o;
    write_entry(0, ent(3, 0, 1, 0, 19'h00001));
    write_entry(1, ent(3, 1, 1, 0, 19'h40000));
    n_cmp++;
    if (bus.state !== 5'd0 || bus.out !== 19'd0) begin
      n_bad++;
      $display("FAIL toggle_hold_on_write: state=%0d out=%h want 0/0", bus.state, bus.out);
    end
    bus.in = 18'h00008;
    bus.en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_s = (k % 2 == 1) ? 5'd1 : 5'd0;
      exp_o = (k % 2 == 1) ? 19'h40000 : 19'h00001;
      n_cmp++;
      if (bus.state !== exp_s || bus.out !== exp_o || bus.stall !== 1'b0) begin
        n_bad++;
        $display("FAIL toggle step%0d: state=%0d out=%h stall=%b want %0d/%h/0",
                 k, bus.state, bus.out, bus.stall, exp_s, exp_o);
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_step();
    logic [4:0]  exp_s;
    logic [18:0] exp_o;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (bus.state !== 5'd1 || bus.out !== 19'h40000) begin
        n_bad++;
        $display("FAIL step_hold idle%0d: state=%0d out=%h want 1/40000", k, bus.state, bus.out);
      end
    end
    bus.step = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp_s = (k % 2 == 1) ? 5'd0 : 5'd1;
      exp_o = (k % 2 == 1) ? 19'h00001 : 19'h40000;
      n_cmp++;
      if (bus.state !== exp_s || bus.out !== exp_o) begin
        n_bad++;
        $display("FAIL step_held edge%0d: state=%0d out=%h want %0d/%h", k, bus.state, bus.out, exp_s, exp_o);
      end
    end
    bus.step = 1'b0;
  endtask

  task automatic test_collision();
    bus.en = 1'b1;
    write_entry(1, ent(3, 1, 1, 0, 19'h7FFFF));
    n_cmp++;
    if (bus.state !== 5'd1 || bus.out !== 19'h40000) begin
      n_bad++;
      $display("FAIL collision_old: state=%0d out=%h want 1/40000", bus.state, bus.out);
    end
    tick();
    tick();
    bus.en = 1'b0;
    n_cmp++;
    if (bus.state !== 5'd1 || bus.out !== 19'h7FFFF) begin
      n_bad++;
      $display("FAIL collision_new: state=%0d out=%h want 1/7ffff", bus.state, bus.out);
    end
    write_entry(1, ent(0, 0, 2, 2, 19'h12345));
    n_cmp++;
    if (bus.state !== 5'd1 || bus.out !== 19'h7FFFF) begin
      n_bad++;
      $display("FAIL current_entry_write: state=%0d out=%h want 1/7ffff", bus.state, bus.out);
    end
  endtask

  task automatic test_out_of_range();
    write_entry(2, ent(31, 1, 5, 6, 19'h00222));
    write_entry(5, ent(0, 0, 2, 2, 19'h00555));
    bus.step = 1'b1;
    tick();
    bus.in = 18'h3FFFF;
    tick();
    n_cmp++;
    if (bus.state !== 5'd5 || bus.out !== 19'h00555) begin
      n_bad++;
      $display("FAIL oor_in_ones: state=%0d out=%h want 5/00555", bus.state, bus.out);
    end
    tick();
    bus.in = 18'h00000;
    tick();
    bus.step = 1'b0;
    n_cmp++;
    if (bus.state !== 5'd5 || bus.out !== 19'h00555) begin
      n_bad++;
      $display("FAIL oor_in_zeros: state=%0d out=%h want 5/00555", bus.state, bus.out);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.en       = 1'b1;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 5'd3;
    bus.cfg_data = ent(0, 0, 4, 4, 19'h00333);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.cfg_we = 1'b0;
    n_cmp++;
    if (bus.state !== 5'd0 || bus.out !== 19'd0 || bus.stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: state=%0d out=%h stall=%b want 0/0/0", bus.state, bus.out, bus.stall);
    end
    tick();
    bus.en = 1'b0;
    n_cmp++;
    if (bus.state !== 5'd0 || bus.out !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_cleared_tbl0: state=%0d out=%h want 0/0", bus.state, bus.out);
    end
    write_entry(0, ent(0, 0, 3, 3, 19'h00100));
    bus.step = 1'b1;
    tick();
    n_cmp++;
    if (bus.state !== 5'd3 || bus.out !== 19'd0) begin
      n_bad++;
      $display("FAIL write_discarded_out: state=%0d out=%h want 3/0", bus.state, bus.out);
    end
    tick();
    bus.step = 1'b0;
    n_cmp++;
    if (bus.state !== 5'd0 || bus.out !== 19'h00100) begin
      n_bad++;
      $display("FAIL write_discarded_nxt: state=%0d out=%h want 0/00100", bus.state, bus.out);
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_step();
    test_collision();
    test_out_of_range();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
